elevator_scan_controller: RTL and testbench
===========================================

Name: elevator_scan_controller

Overview:
- Motion/door sequencer for the elevator car; consumes the latched `floor_requests` vector from `request_handler`.
- Drives `current_floor` and the one-cycle `clear_current_request` pulse back into `request_handler`.
- Schedules service with a SCAN (elevator) policy: keep the current direction while requests remain ahead, then reverse.
- Per-floor travel time and door dwell are modelled with cycle counters.

Parameters:
- NUM_FLOORS, 10, number of floors; floors 0..NUM_FLOORS-1.
- FLOOR_WIDTH, 4, width of the floor index; must satisfy 2^FLOOR_WIDTH >= NUM_FLOORS.
- TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1).
- DOOR_CYCLES, 6, clock cycles the door stays open per stop (>=2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- floor_requests  in  NUM_FLOORS  pending requests from request_handler; bit i = floor i.
- hold  in  1  freezes travel counter in MOVE states and door timer in DOOR_OPEN.
- current_floor  out  FLOOR_WIDTH  car position, registered.
- clear_current_request  out  1  one-cycle pulse; clears the bit at current_floor.
- door_open  out  1  high throughout DOOR_OPEN.
- moving_up  out  1  high in MOVE_UP.
- moving_down  out  1  high in MOVE_DOWN.
- dir_up  out  1  last/committed direction; 1 = up.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - current_floor=0, dir_up=1.
  - clear_current_request, door_open, moving_up and moving_down all 0.
  - Counters 0.
- Derived combinational flags: req_here = floor_requests[current_floor]; req_above = any bit above current_floor; req_below = any bit below current_floor.
- IDLE, priority order:
  - req_here: DOOR_OPEN; clear=1 and door_open=1 on that edge.
  - Else if (dir_up and req_above) or (!req_below and req_above): MOVE_UP, dir_up=1.
  - Else if req_below: MOVE_DOWN, dir_up=0.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - travel_cnt increments each cycle while hold=0; hold=1 freezes it.
  - When travel_cnt==TRAVEL_CYCLES-1 (and hold=0): current_floor steps ±1 on the next edge and travel_cnt returns to 0.
  - Floors therefore advance every TRAVEL_CYCLES cycles.
  - Arrival decision at the step edge, evaluated on the new floor index:
    - Request at new floor: DOOR_OPEN, clear pulse, door_open=1.
    - Else a request further in the same direction: stay in the MOVE state.
    - Else: IDLE (re-evaluation there may reverse direction).
  - Requests at intermediate floors in the travel direction are served when reached.
  - Requests behind the car wait until reversal.
- Limits:
  - current_floor never exceeds NUM_FLOORS-1 or goes below 0.
  - MOVE_UP at the top floor or MOVE_DOWN at floor 0 cannot occur; if entered, the state falls to IDLE without a step.
- DOOR_OPEN:
  - door_cnt runs 0..DOOR_CYCLES-1; frozen while hold=1.
  - Exit to IDLE on the edge after door_cnt==DOOR_CYCLES-1; door_open drops on that edge.
  - First DOOR_OPEN cycle: req_here is ignored, because request_handler clears the bit one edge after the pulse.
  - From door_cnt>=1, req_here=1 (button re-press): clear pulse again and door_cnt restarts at 0.
- clear_current_request:
  - Never high for two consecutive cycles.
  - Always coincides with door_open=1.
- Output flags:
  - moving_up, moving_down and door_open are mutually exclusive.
  - All outputs are registered.
- Reset asserted mid-operation: immediate return to the reset values above; no clear pulse is issued.

Test Plan:
- Reset, current_floor=0, floor_requests=bit3 set at edge k -> MOVE_UP from k+1; current_floor=1,2,3 at k+5,k+9,k+13; door_open=1 and clear 1-cycle pulse at k+13 with current_floor=3; door_open=0 and IDLE at k+19.
- Car at 5 with dir_up=1, requests {2,7} -> serves 7 first (clear with current_floor=7), then reverses to MOVE_DOWN, serves 2; no clear at 6,5,4,3.
- IDLE at floor 4, request bit4 -> DOOR_OPEN next edge, no movement, door_open exactly 6 cycles, one clear pulse.
- hold=1 for 3 cycles during MOVE_UP 0→1 -> floor step delayed by exactly 3 cycles; hold=1 during DOOR_OPEN extends door_open by the hold length.
- Bit of current floor re-asserted at door_cnt=3 -> second clear pulse, door_open total 4+6=10 cycles.
- reset=0 while current_floor=6 and moving_up=1 -> outputs reset asynchronously (current_floor=0, moving_up=0) before the next clk edge; after release with no requests, the block stays in IDLE.

Source files
------------

// File: rtl/elevator_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scan_controller_if
// Brief    : Request/status bundle between request_handler side and car FSM.
// Revision : 1.0
// ============================================================================
interface elevator_scan_controller_if #(
  parameter int NUM_FLOORS  = 10,
  parameter int FLOOR_WIDTH = 4
);
  logic [NUM_FLOORS-1:0]  i_floor_requests;
  logic                   i_hold;
  logic [FLOOR_WIDTH-1:0] o_current_floor;
  logic                   o_clear_current_request;
  logic                   o_door_open;
  logic                   o_moving_up;
  logic                   o_moving_down;
  logic                   o_dir_up;

  modport master (
    output i_floor_requests,
    output i_hold,
    input  o_current_floor,
    input  o_clear_current_request,
    input  o_door_open,
    input  o_moving_up,
    input  o_moving_down,
    input  o_dir_up
  );

  modport slave (
    input  i_floor_requests,
    input  i_hold,
    output o_current_floor,
    output o_clear_current_request,
    output o_door_open,
    output o_moving_up,
    output o_moving_down,
    output o_dir_up
  );
endinterface
`default_nettype wire

// File: rtl/elevator_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scan_controller
// Brief    : SCAN-policy motion/door sequencer with cycle-counted travel/dwell.
// Revision : 1.0
// ============================================================================
module elevator_scan_controller #(
  parameter int NUM_FLOORS    = 10,
  parameter int FLOOR_WIDTH   = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  wire                         clk,
  input  wire                         reset,
  elevator_scan_controller_if.slave   bus
);

  localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);

  localparam logic [TRAVEL_W-1:0]    c_travel_last = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]      c_door_last   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_WIDTH-1:0] c_top_floor   = FLOOR_WIDTH'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_t;

  state_t                 r_state;
  logic [FLOOR_WIDTH-1:0] r_floor;
  logic                   r_dir_up;
  logic [TRAVEL_W-1:0]    r_travel_cnt;
  logic [DOOR_W-1:0]      r_door_cnt;
  logic                   r_clear;
  logic                   r_door_open;
  logic                   r_moving_up;
  logic                   r_moving_down;

  state_t                 w_state_nx;
  logic [FLOOR_WIDTH-1:0] w_floor_nx;
  logic                   w_dir_up_nx;
  logic [TRAVEL_W-1:0]    w_travel_nx;
  logic [DOOR_W-1:0]      w_door_nx;
  logic                   w_clear_nx;

  logic [NUM_FLOORS-1:0]  w_req;
  logic                   w_hold;
  logic [FLOOR_WIDTH-1:0] w_floor_up;
  logic [FLOOR_WIDTH-1:0] w_floor_dn;
  logic [2:0]             w_flags_cur;
  logic [2:0]             w_flags_up;
  logic [2:0]             w_flags_dn;

  // Returns {any below, at floor, any above} for the given floor index.
  function automatic logic [2:0] scan_flags(
    input logic [NUM_FLOORS-1:0]  req,
    input logic [FLOOR_WIDTH-1:0] fl
  );
    logic below;
    logic here;
    logic above;
    below = 1'b0;
    here  = 1'b0;
    above = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_WIDTH'(i) < fl) begin
        below = below | req[i];
      end else if (FLOOR_WIDTH'(i) == fl) begin
        here = here | req[i];
      end else begin
        above = above | req[i];
      end
    end
    return {below, here, above};
  endfunction

  assign w_req       = bus.i_floor_requests;
  assign w_hold      = bus.i_hold;
  assign w_floor_up  = r_floor + FLOOR_WIDTH'(1);
  assign w_floor_dn  = r_floor - FLOOR_WIDTH'(1);
  assign w_flags_cur = scan_flags(w_req, r_floor);
  assign w_flags_up  = scan_flags(w_req, w_floor_up);
  assign w_flags_dn  = scan_flags(w_req, w_floor_dn);

  always_comb begin
    w_state_nx  = r_state;
    w_floor_nx  = r_floor;
    w_dir_up_nx = r_dir_up;
    w_travel_nx = r_travel_cnt;
    w_door_nx   = r_door_cnt;
    w_clear_nx  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_travel_nx = '0;
        w_door_nx   = '0;
        if (w_flags_cur[1]) begin
          w_state_nx = S_DOOR_OPEN;
          w_clear_nx = 1'b1;
        end else if ((r_dir_up && w_flags_cur[0]) || (!w_flags_cur[2] && w_flags_cur[0])) begin
          w_state_nx  = S_MOVE_UP;
          w_dir_up_nx = 1'b1;
        end else if (w_flags_cur[2]) begin
          w_state_nx  = S_MOVE_DOWN;
          w_dir_up_nx = 1'b0;
        end
      end

      S_MOVE_UP: begin
        if (r_floor == c_top_floor) begin
          w_state_nx  = S_IDLE;
          w_travel_nx = '0;
        end else if (!w_hold) begin
          if (r_travel_cnt == c_travel_last) begin
            w_floor_nx  = w_floor_up;
            w_travel_nx = '0;
            // Arrival decision is made against the floor being stepped onto.
            if (w_flags_up[1]) begin
              w_state_nx = S_DOOR_OPEN;
              w_clear_nx = 1'b1;
            end else if (!w_flags_up[0]) begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_travel_nx = r_travel_cnt + TRAVEL_W'(1);
          end
        end
      end

      S_MOVE_DOWN: begin
        if (r_floor == '0) begin
          w_state_nx  = S_IDLE;
          w_travel_nx = '0;
        end else if (!w_hold) begin
          if (r_travel_cnt == c_travel_last) begin
            w_floor_nx  = w_floor_dn;
            w_travel_nx = '0;
            if (w_flags_dn[1]) begin
              w_state_nx = S_DOOR_OPEN;
              w_clear_nx = 1'b1;
            end else if (!w_flags_dn[2]) begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_travel_nx = r_travel_cnt + TRAVEL_W'(1);
          end
        end
      end

      S_DOOR_OPEN: begin
        // On door_cnt 0 the request bit is still the one just cleared.
        if ((r_door_cnt != '0) && w_flags_cur[1]) begin
          w_clear_nx = 1'b1;
          w_door_nx  = '0;
        end else if (!w_hold) begin
          if (r_door_cnt == c_door_last) begin
            w_state_nx = S_IDLE;
            w_door_nx  = '0;
          end else begin
            w_door_nx = r_door_cnt + DOOR_W'(1);
          end
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_floor       <= '0;
      r_dir_up      <= 1'b1;
      r_travel_cnt  <= '0;
      r_door_cnt    <= '0;
      r_clear       <= 1'b0;
      r_door_open   <= 1'b0;
      r_moving_up   <= 1'b0;
      r_moving_down <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_floor       <= w_floor_nx;
      r_dir_up      <= w_dir_up_nx;
      r_travel_cnt  <= w_travel_nx;
      r_door_cnt    <= w_door_nx;
      r_clear       <= w_clear_nx;
      r_door_open   <= (w_state_nx == S_DOOR_OPEN);
      r_moving_up   <= (w_state_nx == S_MOVE_UP);
      r_moving_down <= (w_state_nx == S_MOVE_DOWN);
    end
  end

  assign bus.o_current_floor         = r_floor;
  assign bus.o_clear_current_request = r_clear;
  assign bus.o_door_open             = r_door_open;
  assign bus.o_moving_up             = r_moving_up;
  assign bus.o_moving_down           = r_moving_down;
  assign bus.o_dir_up                = r_dir_up;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scan_controller
// Brief    : Scoreboard bench: expected floor/door events queued, monitor pops.
// Revision : 1.0
// ============================================================================
module tb_elevator_scan_controller;

  localparam int NF = 10;
  localparam int FW = 4;
  localparam int K_STEP = 0;
  localparam int K_CLR  = 1;
  localparam int K_DCL  = 2;

  typedef struct {
    int kind;
    int fl;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] press = '0;
  logic [NF-1:0] latched;
  int            cyc = 0;
  int            base = 0;
  int            checks = 0;
  int            failures = 0;
  ev_t           exp_q[$];

  int            prev_floor = 0;
  int            prev_door = 0;
  int            prev_clr = 0;

  elevator_scan_controller_if #(.NUM_FLOORS(NF), .FLOOR_WIDTH(FW)) bus ();

  elevator_scan_controller #(
    .NUM_FLOORS(NF), .FLOOR_WIDTH(FW), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // request_handler model: latch presses, drop the bit one edge after a clear.
  function automatic logic [NF-1:0] handler_next(input logic [NF-1:0] l, input logic [NF-1:0] p,
                                                 input logic c, input int f);
    logic [NF-1:0] n;
    n = l | p;
    for (int i = 0; i < NF; i++) if (c && i == f) n[i] = 1'b0;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) latched <= '0;
    else latched <= handler_next(latched, press, bus.o_clear_current_request, int'(bus.o_current_floor));
  end

  assign bus.i_floor_requests = latched | press;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_ev(input int kind, input int fl, input int off);
    ev_t e;
    e.kind = kind;
    e.fl   = fl;
    e.cyc  = base + off;
    exp_q.push_back(e);
  endtask

  task automatic match_event(input int kind, input int fl);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_event_kind%0d", kind), fl, -1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind@%0d", e.cyc), kind, e.kind);
      check($sformatf("event_floor@%0d", e.cyc), fl, e.fl);
      check($sformatf("event_cycle_kind%0d", e.kind), cyc, e.cyc);
    end
  endtask

  task automatic monitor_sample();
    int fl;
    int nflags;
    fl = int'(bus.o_current_floor);
    if (fl != prev_floor) match_event(K_STEP, fl);
    if (bus.o_clear_current_request) begin
      match_event(K_CLR, fl);
      check("clear_with_door", int'(bus.o_door_open), 1);
      check("clear_not_back_to_back", prev_clr, 0);
    end
    if (prev_door == 1 && !bus.o_door_open) match_event(K_DCL, fl);
    nflags = int'(bus.o_door_open) + int'(bus.o_moving_up) + int'(bus.o_moving_down);
    check("flags_exclusive", int'(nflags <= 1), 1);
    prev_floor = fl;
    prev_door  = int'(bus.o_door_open);
    prev_clr   = int'(bus.o_clear_current_request);
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press_floors(input logic [NF-1:0] m);
    press = m;
    @(negedge clk);
    press = '0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_events_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_state(input string tag, input int fl, input int door,
                             input int mu, input int md, input int dir);
    check({tag, "_floor"},       int'(bus.o_current_floor), fl);
    check({tag, "_door_open"},   int'(bus.o_door_open), door);
    check({tag, "_moving_up"},   int'(bus.o_moving_up), mu);
    check({tag, "_moving_down"}, int'(bus.o_moving_down), md);
    check({tag, "_dir_up"},      int'(bus.o_dir_up), dir);
  endtask

  initial begin
    bus.i_hold = 1'b0;
    fork
      forever begin
        @(negedge clk);
        monitor_sample();
      end
    join_none

    #1 reset = 1'b0;
    #1;
    check_state("reset", 0, 0, 0, 0, 1);
    check("reset_clear", int'(bus.o_clear_current_request), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Floor 0 -> 3: a step every 4 cycles, 6-cycle door dwell.
    base = cyc;
    exp_ev(K_STEP, 1, 5);
    exp_ev(K_STEP, 2, 9);
    exp_ev(K_STEP, 3, 13);
    exp_ev(K_CLR, 3, 13);
    exp_ev(K_DCL, 3, 19);
    press_floors(10'b0000001000);
    at_cycle(base + 2);
    check_state("first_move", 0, 0, 1, 0, 1);
    wait_drain("go_to_3");
    check_state("idle_at_3", 3, 0, 0, 0, 1);

    // Reach floor 5 heading up.
    base = cyc;
    exp_ev(K_STEP, 4, 5);
    exp_ev(K_STEP, 5, 9);
    exp_ev(K_CLR, 5, 9);
    exp_ev(K_DCL, 5, 15);
    press_floors(10'b0000100000);
    wait_drain("go_to_5");

    // At 5 going up with {2,7}: serve 7, reverse, pass 6..3, serve 2.
    base = cyc;
    exp_ev(K_STEP, 6, 5);
    exp_ev(K_STEP, 7, 9);
    exp_ev(K_CLR, 7, 9);
    exp_ev(K_DCL, 7, 15);
    exp_ev(K_STEP, 6, 20);
    exp_ev(K_STEP, 5, 24);
    exp_ev(K_STEP, 4, 28);
    exp_ev(K_STEP, 3, 32);
    exp_ev(K_STEP, 2, 36);
    exp_ev(K_CLR, 2, 36);
    exp_ev(K_DCL, 2, 42);
    press_floors(10'b0010000100);
    at_cycle(base + 17);
    check_state("reversed", 7, 0, 0, 1, 0);
    wait_drain("scan_2_7");
    check_state("idle_at_2", 2, 0, 0, 0, 0);

    // Dir down, nothing below: go up to 4.
    base = cyc;
    exp_ev(K_STEP, 3, 5);
    exp_ev(K_STEP, 4, 9);
    exp_ev(K_CLR, 4, 9);
    exp_ev(K_DCL, 4, 15);
    press_floors(10'b0000010000);
    wait_drain("go_to_4");

    // Request at the current floor: door opens next edge for 6 cycles.
    base = cyc;
    exp_ev(K_CLR, 4, 1);
    exp_ev(K_DCL, 4, 7);
    press_floors(10'b0000010000);
    check_state("door_here", 4, 1, 0, 0, 1);
    wait_drain("door_here");

    // Hold 3 cycles in travel, 2 cycles in door dwell.
    base = cyc;
    exp_ev(K_STEP, 5, 8);
    exp_ev(K_CLR, 5, 8);
    exp_ev(K_DCL, 5, 16);
    press_floors(10'b0000100000);
    at_cycle(base + 2);
    bus.i_hold = 1'b1;
    at_cycle(base + 5);
    bus.i_hold = 1'b0;
    check("held_floor", int'(bus.o_current_floor), 4);
    at_cycle(base + 10);
    bus.i_hold = 1'b1;
    at_cycle(base + 12);
    bus.i_hold = 1'b0;
    wait_drain("hold");

    // Re-press at door_cnt=3: second clear, door open 10 cycles total.
    base = cyc;
    exp_ev(K_CLR, 5, 1);
    exp_ev(K_CLR, 5, 5);
    exp_ev(K_DCL, 5, 11);
    press_floors(10'b0000100000);
    at_cycle(base + 4);
    press_floors(10'b0000100000);
    at_cycle(base + 10);
    check("door_still_open", int'(bus.o_door_open), 1);
    wait_drain("repress");

    // Asynchronous reset while moving up at floor 6.
    base = cyc;
    exp_ev(K_STEP, 6, 5);
    exp_ev(K_STEP, 0, 7);
    press_floors(10'b0100000000);
    at_cycle(base + 6);
    check_state("pre_reset", 6, 0, 1, 0, 1);
    #1 reset = 1'b0;
    #1;
    check_state("async_reset", 0, 0, 0, 0, 1);
    check("async_reset_clear", int'(bus.o_clear_current_request), 0);
    at_cycle(base + 9);
    reset = 1'b1;
    wait_drain("reset_mid");
    repeat (10) @(negedge clk);
    check_state("post_reset_idle", 0, 0, 0, 0, 1);
    check("no_stray_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
